maxnet_controller: RTL
======================

Name: maxnet_controller

Overview:
Sequencer for the MaxNet competition datapath (lane registers, inhibition update, output zero-check). It loads the initial activations and waits for datapath settle latency. It then samples the per-lane zero flags and issues update iterations until one of three outcomes: exactly one lane is non-zero (winner), all lanes are zero (tie collapse), or the iteration limit is reached (timeout). It reports the winner index and status with a start/done handshake.

Parameters:
NUM, 4, number of competing lanes (2..8)
IDX_W, 2, winner index width, equal to clog2(NUM)
ITER_W, 8, iteration counter width
MAX_ITER, 255, maximum update iterations before timeout (1..2^ITER_W-1)
LAT, 2, datapath settle cycles after load or update before zero flags are valid (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  request a new competition; sampled only in IDLE
abort  in  1  cancel the run in progress
x_zero  in  NUM  per-lane flag from the datapath; 1 = lane magnitude bits are zero (sign ignored)
load_en  out  1  one-cycle pulse: datapath loads the initial activations
upd_en  out  1  one-cycle pulse: datapath performs one inhibition iteration
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the result is final
result_valid  out  1  high from done until the next accepted start, abort or rst
winner  out  IDX_W  index of the surviving lane; 0 unless status = 00
status  out  2  00 winner, 01 all-zero, 10 timeout, 11 unused
iter_count  out  ITER_W  number of upd_en pulses issued in the current or last run

Behaviour:
- All outputs are registered.
- On rst, next edge: state IDLE, all outputs 0. rst has priority over abort and start in every state.
- States: IDLE, LOAD, WAIT, CHECK, UPDATE, DONE.
- IDLE: start=1 -> LOAD. On the same edge, clear result_valid, winner, status and iter_count.
- LOAD, one cycle: load_en=1. Load the wait counter with LAT. Next state is WAIT.
- WAIT, exactly LAT cycles: decrement the wait counter. When it expires, go to CHECK.
- CHECK, one cycle: compute z = popcount(x_zero).
  - z == NUM: go to DONE with status=01, winner=0.
  - z == NUM-1: go to DONE with status=00, winner = index of the single 0 bit in x_zero.
  - Else, if iter_count == MAX_ITER: go to DONE with status=10, winner=0.
  - Else: go to UPDATE.
  - Winner and all-zero are tested before timeout. A result that appears at the MAX_ITER-th check therefore reports success.
- UPDATE, one cycle: upd_en=1, iter_count += 1, reload the wait counter with LAT. Next state is WAIT.
- DONE, one cycle: done=1, result_valid=1. Next state is IDLE.
  - winner, status and iter_count hold until the next accepted start, abort or rst.
- Latency, with start sampled at edge E0:
  - done is visible after edge E(LAT+3).
  - Each update iteration adds LAT+2 cycles.
  - With LAT=2 and k iterations, done appears 5+4k cycles after E0.
- start while busy=1, including the DONE cycle, is ignored; no queuing.
- abort=1 in any non-IDLE state: next edge goes to IDLE.
  - No done pulse.
  - load_en, upd_en and result_valid go to 0.
  - iter_count keeps its value.
  - abort in IDLE has no effect.
- x_zero is only sampled in CHECK; values in other states are don't-care.
- iter_count never wraps, because it is bounded by MAX_ITER.

Test Plan:
- Immediate winner: LAT=2; start; x_zero=4'b1101 at CHECK -> single load_en, no upd_en; done 5 cycles after start; winner=1, status=00, iter_count=0.
- Converge after 3 iterations: x_zero=0000, 0000, 0100, then 1011 at successive CHECKs -> three upd_en pulses spaced 4 cycles apart; done at cycle 17; winner=2, status=00, iter_count=3.
- All-zero collapse: x_zero=0000 at the first CHECK, then 1111 -> status=01, winner=0, iter_count=1.
- Timeout, MAX_ITER=4: x_zero held at 0000 -> exactly 4 upd_en pulses; status=10, iter_count=4. Also: x_zero=1110 at the 5th CHECK -> status=00, winner=0.
- Abort, plus start while busy: start; pulse start again during WAIT (ignored); assert abort during the second WAIT -> IDLE next edge, no done, result_valid=0, iter_count=1. A new start afterwards runs normally.
- Reset mid-run: assert rst during UPDATE -> next edge all outputs 0, state IDLE. A start one cycle after rst deasserts is accepted.

Source files
------------

// File: rtl/maxnet_controller.sv
// Sequencer for the MaxNet competition datapath: load, settle, zero-check and
// inhibition iterations until a single survivor, total collapse or timeout.
module maxnet_controller #(
    parameter int NUM      = 4,
    parameter int IDX_W    = 2,
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255,
    parameter int LAT      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM-1:0]    x_zero,
    output logic              load_en,
    output logic              upd_en,
    output logic              busy,
    output logic              done,
    output logic              result_valid,
    output logic [IDX_W-1:0]  winner,
    output logic [1:0]        status,
    output logic [ITER_W-1:0] iter_count
);

    // state  | meaning
    // IDLE   | waiting for start
    // LOAD   | datapath loads initial activations
    // WAIT   | datapath settling for LAT cycles
    // CHECK  | evaluate the per-lane zero flags
    // UPDATE | one inhibition iteration
    // DONE   | result final, done pulse issued on exit
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [1:0] ST_WINNER  = 2'b00;
    localparam logic [1:0] ST_ALLZERO = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    localparam int WAIT_W = $clog2(LAT + 1);
    localparam int ZC_W   = $clog2(NUM + 1);

    logic [2:0]        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ZC_W-1:0]   zero_cnt;
    logic [IDX_W-1:0]  zero_idx;

    // zero_idx is only meaningful when exactly one lane is non-zero
    always_comb begin
        zero_cnt = '0;
        zero_idx = '0;
        for (int i = 0; i < NUM; i++) begin
            zero_cnt = zero_cnt + ZC_W'(x_zero[i]);
            if (!x_zero[i]) begin
                zero_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            load_en      <= 1'b0;
            upd_en       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            winner       <= '0;
            status       <= 2'b00;
            iter_count   <= '0;
        end else begin
            load_en <= 1'b0;
            upd_en  <= 1'b0;
            done    <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                // iter_count is kept so the aborted run can still be inspected
                state        <= S_IDLE;
                busy         <= 1'b0;
                result_valid <= 1'b0;
                winner       <= '0;
                status       <= 2'b00;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state        <= S_LOAD;
                            busy         <= 1'b1;
                            result_valid <= 1'b0;
                            winner       <= '0;
                            status       <= 2'b00;
                            iter_count   <= '0;
                        end
                    end
                    S_LOAD: begin
                        load_en  <= 1'b1;
                        wait_cnt <= WAIT_W'(LAT);
                        state    <= S_WAIT;
                    end
                    S_WAIT: begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                        if (wait_cnt <= WAIT_W'(1)) begin
                            state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        // outcomes take precedence over the iteration limit
                        if (zero_cnt == ZC_W'(NUM)) begin
                            status <= ST_ALLZERO;
                            winner <= '0;
                            state  <= S_DONE;
                        end else if (zero_cnt == ZC_W'(NUM - 1)) begin
                            status <= ST_WINNER;
                            winner <= zero_idx;
                            state  <= S_DONE;
                        end else if (iter_count == ITER_W'(MAX_ITER)) begin
                            status <= ST_TIMEOUT;
                            winner <= '0;
                            state  <= S_DONE;
                        end else begin
                            state <= S_UPDATE;
                        end
                    end
                    S_UPDATE: begin
                        upd_en     <= 1'b1;
                        iter_count <= iter_count + ITER_W'(1);
                        wait_cnt   <= WAIT_W'(LAT);
                        state      <= S_WAIT;
                    end
                    S_DONE: begin
                        done         <= 1'b1;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
